// File: rtl/nn_paket.sv
// Constants and state encoding shared by the mine/rock classifier blocks.
package nn_paket;

  localparam int SIRINA        = 16;
  localparam int BROJ_ZNACAJKI = 60;

  typedef enum logic [1:0] {
    PUNJENJE = 2'd0,
    CEKANJE  = 2'd1,
    REZULTAT = 2'd2
  } stanje_t;

endpackage

// File: rtl/ucitavac_uzorka_if.sv
// Sample stream, network connection and result handshake of the sample loader.
interface ucitavac_uzorka_if #(
  parameter int SIRINA        = nn_paket::SIRINA,
  parameter int BROJ_ZNACAJKI = nn_paket::BROJ_ZNACAJKI
);

  logic [SIRINA-1:0]               ulaz_podatak;
  logic                            ulaz_valid;
  logic                            ulaz_ready;
  logic                            odbaci;
  logic [SIRINA*BROJ_ZNACAJKI-1:0] uzorak;
  logic [SIRINA-1:0]               nn_izlaz_1;
  logic [SIRINA-1:0]               nn_izlaz_2;
  logic                            nn_indikator_1;
  logic                            nn_indikator_2;
  logic [SIRINA-1:0]               rez_izlaz_1;
  logic [SIRINA-1:0]               rez_izlaz_2;
  logic                            rez_indikator_1;
  logic                            rez_indikator_2;
  logic                            rez_valid;
  logic                            rez_ready;
  logic [15:0]                     broj_uzoraka;

  // Loader side.
  modport slave (
    input  ulaz_podatak, ulaz_valid, odbaci,
    input  nn_izlaz_1, nn_izlaz_2, nn_indikator_1, nn_indikator_2,
    input  rez_ready,
    output ulaz_ready, uzorak,
    output rez_izlaz_1, rez_izlaz_2, rez_indikator_1, rez_indikator_2,
    output rez_valid, broj_uzoraka
  );

  // Producer / network / consumer side.
  modport master (
    output ulaz_podatak, ulaz_valid, odbaci,
    output nn_izlaz_1, nn_izlaz_2, nn_indikator_1, nn_indikator_2,
    output rez_ready,
    input  ulaz_ready, uzorak,
    input  rez_izlaz_1, rez_izlaz_2, rez_indikator_1, rez_indikator_2,
    input  rez_valid, broj_uzoraka
  );

endinterface

// File: rtl/ucitavac_uzorka.sv
// Loads one sonar sample word by word, lets Neural_net settle, then holds the
// registered network result until the consumer takes it.
module ucitavac_uzorka #(
  parameter int SIRINA        = nn_paket::SIRINA,
  parameter int BROJ_ZNACAJKI = nn_paket::BROJ_ZNACAJKI,
  parameter int SMIRIVANJE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  ucitavac_uzorka_if.slave  veza
);

  import nn_paket::*;

  localparam int SIRINA_VEKTORA = SIRINA * BROJ_ZNACAJKI;
  localparam int BR_W = (BROJ_ZNACAJKI > 1) ? $clog2(BROJ_ZNACAJKI) : 1;
  localparam int SM_W = (SMIRIVANJE > 1) ? $clog2(SMIRIVANJE) : 1;
  localparam logic [BR_W-1:0] ZADNJA_RIJEC = BR_W'(BROJ_ZNACAJKI - 1);
  localparam logic [SM_W-1:0] ZADNJI_SMIR  = SM_W'(SMIRIVANJE - 1);

  stanje_t                   r_stanje;
  stanje_t                   w_stanje_next;
  logic [BR_W-1:0]           r_brojac_rijeci;
  logic [SM_W-1:0]           r_brojac_smir;
  logic [SIRINA_VEKTORA-1:0] r_uzorak;
  logic [SIRINA-1:0]         r_rez_izlaz_1;
  logic [SIRINA-1:0]         r_rez_izlaz_2;
  logic                      r_rez_indikator_1;
  logic                      r_rez_indikator_2;
  logic                      r_rez_valid;
  logic [15:0]               r_broj_uzoraka;

  logic                      w_ulaz_ready;
  logic                      w_prihvat;
  logic                      w_upis;
  logic                      w_zadnja;
  logic                      w_smiren;
  logic                      w_predaja;
  logic [SIRINA_VEKTORA-1:0] w_uzorak_pomaknut;

  assign w_ulaz_ready = (r_stanje == PUNJENJE);
  assign w_prihvat    = veza.ulaz_valid && w_ulaz_ready;
  // A word accepted together with odbaci is swallowed without being stored.
  assign w_upis       = w_prihvat && !veza.odbaci;
  assign w_zadnja     = w_upis && (r_brojac_rijeci == ZADNJA_RIJEC);
  assign w_smiren     = (r_stanje == CEKANJE) && (r_brojac_smir == ZADNJI_SMIR);
  assign w_predaja    = (r_stanje == REZULTAT) && r_rez_valid && veza.rez_ready;

  // New word enters at the top so the first word ends up at the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < BROJ_ZNACAJKI - 1; gi++) begin : g_pomak
      assign w_uzorak_pomaknut[gi*SIRINA +: SIRINA] = r_uzorak[(gi+1)*SIRINA +: SIRINA];
    end
  endgenerate
  assign w_uzorak_pomaknut[SIRINA_VEKTORA-1 -: SIRINA] = veza.ulaz_podatak;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stanje <= PUNJENJE;
    end else begin
      r_stanje <= w_stanje_next;
    end
  end

  always_comb begin
    w_stanje_next = r_stanje;
    unique case (r_stanje)
      PUNJENJE: if (w_zadnja)  w_stanje_next = CEKANJE;
      CEKANJE:  if (w_smiren)  w_stanje_next = REZULTAT;
      REZULTAT: if (w_predaja) w_stanje_next = PUNJENJE;
      default:                 w_stanje_next = PUNJENJE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brojac_rijeci   <= '0;
      r_brojac_smir     <= '0;
      r_uzorak          <= '0;
      r_rez_izlaz_1     <= '0;
      r_rez_izlaz_2     <= '0;
      r_rez_indikator_1 <= 1'b0;
      r_rez_indikator_2 <= 1'b0;
      r_rez_valid       <= 1'b0;
      r_broj_uzoraka    <= '0;
    end else begin
      if (r_stanje == PUNJENJE) begin
        if (veza.odbaci) begin
          r_brojac_rijeci <= '0;
        end else if (w_prihvat) begin
          r_uzorak        <= w_uzorak_pomaknut;
          r_brojac_rijeci <= w_zadnja ? '0 : r_brojac_rijeci + BR_W'(1);
        end
      end

      if (r_stanje == CEKANJE) begin
        r_brojac_smir <= w_smiren ? '0 : r_brojac_smir + SM_W'(1);
      end

      if (w_smiren) begin
        r_rez_izlaz_1     <= veza.nn_izlaz_1;
        r_rez_izlaz_2     <= veza.nn_izlaz_2;
        r_rez_indikator_1 <= veza.nn_indikator_1;
        r_rez_indikator_2 <= veza.nn_indikator_2;
        r_rez_valid       <= 1'b1;
      end else if (w_predaja) begin
        r_rez_valid    <= 1'b0;
        r_broj_uzoraka <= r_broj_uzoraka + 16'd1;
      end
    end
  end

  assign veza.ulaz_ready      = w_ulaz_ready;
  assign veza.uzorak          = r_uzorak;
  assign veza.rez_izlaz_1     = r_rez_izlaz_1;
  assign veza.rez_izlaz_2     = r_rez_izlaz_2;
  assign veza.rez_indikator_1 = r_rez_indikator_1;
  assign veza.rez_indikator_2 = r_rez_indikator_2;
  assign veza.rez_valid       = r_rez_valid;
  assign veza.broj_uzoraka    = r_broj_uzoraka;

endmodule

// File: tb/tb_ucitavac_uzorka.sv
// Directed bench for the sample loader: reset, load, back-pressure, discard, streaming.
module tb_ucitavac_uzorka;

  localparam int W  = 16;
  localparam int N  = 60;
  localparam int VW = W * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ucitavac_uzorka_if #(.SIRINA(W), .BROJ_ZNACAJKI(N)) veza ();

  ucitavac_uzorka #(.SIRINA(W), .BROJ_ZNACAJKI(N), .SMIRIVANJE(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .veza (veza)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_broj = 16'd0;
  logic [VW-1:0] exp_uzorak;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nn(input logic [15:0] a, input logic [15:0] b, input logic i1, input logic i2);
    veza.nn_izlaz_1     = a;
    veza.nn_izlaz_2     = b;
    veza.nn_indikator_1 = i1;
    veza.nn_indikator_2 = i2;
  endtask

  task automatic build_exp(input logic [15:0] base);
    for (int i = 0; i < N; i++) exp_uzorak[i*W +: W] = base + 16'(i);
  endtask

  task automatic drive_words(input logic [15:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      veza.ulaz_podatak = base + 16'(i);
      veza.ulaz_valid   = 1'b1;
      step();
    end
    veza.ulaz_valid = 1'b0;
  endtask

  task automatic handshake();
    veza.rez_ready = 1'b1;
    step();
    veza.rez_ready = 1'b0;
  endtask

  task automatic test_reset();
    veza.ulaz_podatak = '0; veza.ulaz_valid = 1'b0; veza.odbaci = 1'b0; veza.rez_ready = 1'b0;
    set_nn(16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (veza.ulaz_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_in_reset: got %b need 1", veza.ulaz_ready); end
    checks++; if (veza.uzorak !== '0) begin errors++; $display("FAIL rst_uzorak: got top %h need 0", veza.uzorak[VW-1 -: W]); end
    checks++; if ({veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2} !== '0) begin
      errors++; $display("FAIL rst_rez: got v=%b %h %h %b %b need zeros", veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2); end
    checks++; if (veza.broj_uzoraka !== 16'd0) begin errors++; $display("FAIL rst_broj: got %h need 0", veza.broj_uzoraka); end
    @(negedge clk); rst = 1'b0;
    step();
    checks++; if (veza.ulaz_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b need 1", veza.ulaz_ready); end
    drive_words(16'h0AA0, 10);
    checks++; if (veza.uzorak[VW-1 -: W] !== 16'h0AA9) begin errors++; $display("FAIL partial_top: got %h need 0aa9", veza.uzorak[VW-1 -: W]); end
    #3 rst = 1'b1;
    #1;
    checks++; if (veza.uzorak !== '0 || veza.ulaz_ready !== 1'b1) begin
      errors++; $display("FAIL async_rst: got top %h ready %b need 0 / 1", veza.uzorak[VW-1 -: W], veza.ulaz_ready); end
    @(negedge clk); rst = 1'b0;
    exp_broj = 16'd0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    set_nn(16'h8001, 16'h1234, 1'b1, 1'b0);
    drive_words(16'h0001, N);
    build_exp(16'h0001);
    checks++; if (veza.ulaz_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b need 0", veza.ulaz_ready); end
    checks++; if (veza.uzorak[15:0] !== 16'h0001 || veza.uzorak[959:944] !== 16'h003C) begin
      errors++; $display("FAIL b2b_ends: got %h/%h need 0001/003c", veza.uzorak[15:0], veza.uzorak[959:944]); end
    checks++; if (veza.uzorak !== exp_uzorak) begin errors++; $display("FAIL b2b_uzorak: got word30 %h need %h", veza.uzorak[30*W +: W], exp_uzorak[30*W +: W]); end
    checks++; if (veza.rez_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_e0: got %b need 0", veza.rez_valid); end
    step();
    checks++; if (veza.rez_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_e1: got %b need 0", veza.rez_valid); end
    step();
    checks++; if (veza.rez_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_e2: got %b need 1", veza.rez_valid); end
    checks++; if ({veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2} !== {16'h8001, 16'h1234, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_data: got %h %h %b %b need 8001 1234 1 0", veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2); end
    handshake();
    exp_broj++;
    checks++; if (veza.broj_uzoraka !== exp_broj || veza.rez_valid !== 1'b0 || veza.ulaz_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_handshake: got broj %h v %b rdy %b need %h 0 1", veza.broj_uzoraka, veza.rez_valid, veza.ulaz_ready, exp_broj); end
    checks++; if (veza.rez_izlaz_1 !== 16'h8001) begin errors++; $display("FAIL b2b_retain: got %h need 8001", veza.rez_izlaz_1); end
    $display("test_back_to_back done");
  endtask

  task automatic test_back_pressure();
    set_nn(16'h7F00, 16'h00FF, 1'b0, 1'b1);
    drive_words(16'h0200, N);
    build_exp(16'h0200);
    step(); step();
    checks++; if (veza.rez_valid !== 1'b1 || veza.rez_izlaz_1 !== 16'h7F00) begin
      errors++; $display("FAIL bp_result: got v %b %h need 1 7f00", veza.rez_valid, veza.rez_izlaz_1); end
    for (int c = 0; c < 10; c++) begin
      set_nn(16'(c * 37 + 5), 16'hA5A5 ^ 16'(c), c[0], ~c[0]);
      veza.ulaz_podatak = 16'hDEAD;
      veza.ulaz_valid   = c[0];
      step();
      checks++;
      if ({veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2, veza.ulaz_ready} !==
          {1'b1, 16'h7F00, 16'h00FF, 1'b0, 1'b1, 1'b0} || veza.uzorak !== exp_uzorak || veza.broj_uzoraka !== exp_broj) begin
        errors++; $display("FAIL bp_hold_%0d: got v %b %h %h %b %b rdy %b bot %h need 1 7f00 00ff 0 1 0 0200", c,
          veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2, veza.ulaz_ready, veza.uzorak[15:0]);
      end
    end
    veza.ulaz_valid = 1'b0;
    handshake();
    exp_broj++;
    checks++; if (veza.broj_uzoraka !== exp_broj || veza.rez_valid !== 1'b0) begin
      errors++; $display("FAIL bp_handshake: got broj %h v %b need %h 0", veza.broj_uzoraka, veza.rez_valid, exp_broj); end
    $display("test_back_pressure done");
  endtask

  task automatic test_reset_mid_load();
    int seen;
    drive_words(16'h0500, 45);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (veza.uzorak !== '0 || veza.rez_izlaz_1 !== 16'h0 || veza.rez_izlaz_2 !== 16'h0 || veza.rez_indikator_2 !== 1'b0 ||
        veza.rez_valid !== 1'b0 || veza.broj_uzoraka !== 16'd0 || veza.ulaz_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_clear: got top %h r1 %h r2 %h i2 %b v %b broj %h rdy %b need zeros, rdy 1",
        veza.uzorak[VW-1 -: W], veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_2, veza.rez_valid, veza.broj_uzoraka, veza.ulaz_ready);
    end
    @(negedge clk); rst = 1'b0;
    exp_broj = 16'd0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin step(); if (veza.rez_valid === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_result: got %0d valid cycles need 0", seen); end
    set_nn(16'h0F0F, 16'hF0F0, 1'b1, 1'b1);
    drive_words(16'h0300, N);
    build_exp(16'h0300);
    checks++; if (veza.uzorak !== exp_uzorak) begin errors++; $display("FAIL midrst_uzorak: got %h/%h need 0300/033b", veza.uzorak[15:0], veza.uzorak[959:944]); end
    step(); step();
    checks++; if ({veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2} !== {1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL midrst_result: got v %b %h %h %b %b need 1 0f0f f0f0 1 1", veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2, veza.rez_indikator_1, veza.rez_indikator_2); end
    handshake();
    exp_broj++;
    checks++; if (veza.broj_uzoraka !== 16'd1) begin errors++; $display("FAIL midrst_broj: got %h need 1", veza.broj_uzoraka); end
    $display("test_reset_mid_load done");
  endtask

  task automatic test_gapped_discard();
    int seen;
    set_nn(16'h1357, 16'h2468, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      veza.ulaz_podatak = 16'h0900 + 16'(i);
      veza.ulaz_valid   = 1'b1;
      step();
      veza.ulaz_valid   = 1'b0;
      step();
    end
    veza.odbaci = 1'b1; veza.ulaz_valid = 1'b1; veza.ulaz_podatak = 16'hBEEF;
    step();
    veza.odbaci = 1'b0; veza.ulaz_valid = 1'b0;
    checks++; if (veza.ulaz_ready !== 1'b1 || veza.uzorak[VW-1 -: W] !== 16'h091D) begin
      errors++; $display("FAIL disc_dropped: got rdy %b top %h need 1 091d", veza.ulaz_ready, veza.uzorak[VW-1 -: W]); end
    drive_words(16'h0100, N);
    build_exp(16'h0100);
    checks++; if (veza.ulaz_ready !== 1'b0) begin errors++; $display("FAIL disc_ready_low: got %b need 0", veza.ulaz_ready); end
    checks++; if (veza.uzorak[15:0] !== 16'h0100 || veza.uzorak[959:944] !== 16'h013B || veza.uzorak !== exp_uzorak) begin
      errors++; $display("FAIL disc_uzorak: got %h/%h need 0100/013b", veza.uzorak[15:0], veza.uzorak[959:944]); end
    step(); step();
    checks++; if ({veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2} !== {1'b1, 16'h1357, 16'h2468}) begin
      errors++; $display("FAIL disc_result: got v %b %h %h need 1 1357 2468", veza.rez_valid, veza.rez_izlaz_1, veza.rez_izlaz_2); end
    handshake();
    exp_broj++;
    seen = 0;
    for (int c = 0; c < 5; c++) begin step(); if (veza.rez_valid === 1'b1 || veza.ulaz_ready !== 1'b1) seen++; end
    checks++; if (seen !== 0 || veza.broj_uzoraka !== exp_broj) begin
      errors++; $display("FAIL disc_single: got %0d bad cycles broj %h need 0 %h", seen, veza.broj_uzoraka, exp_broj); end
    $display("test_gapped_discard done");
  endtask

  task automatic test_streaming();
    int   t [3];
    int   idx;
    int   nres;
    logic acc;
    logic [15:0] lo_exp;
    set_nn(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    veza.rez_ready = 1'b1;
    veza.ulaz_valid = 1'b1;
    idx = 0;
    nres = 0;
    for (int cyc = 0; cyc < 400 && nres < 3; cyc++) begin
      veza.ulaz_podatak = 16'h0400 + 16'(idx);
      acc = veza.ulaz_ready;
      if (nres == 2 && idx == 3 * N) veza.ulaz_valid = 1'b0;
      step();
      if (acc && veza.ulaz_valid) idx++;
      if (veza.rez_valid === 1'b1) begin
        t[nres] = cyc;
        lo_exp = 16'h0400 + 16'(nres * N);
        checks++; if (veza.uzorak[15:0] !== lo_exp || veza.uzorak[959:944] !== lo_exp + 16'd59 || veza.rez_izlaz_1 !== 16'hAAAA) begin
          errors++; $display("FAIL stream_sample_%0d: got %h/%h r1 %h need %h/%h aaaa", nres, veza.uzorak[15:0], veza.uzorak[959:944], veza.rez_izlaz_1, lo_exp, lo_exp + 16'd59); end
        nres++;
      end
    end
    veza.ulaz_valid = 1'b0;
    checks++; if (nres !== 3) begin errors++; $display("FAIL stream_timeout: got %0d results need 3", nres); end
    step();
    veza.rez_ready = 1'b0;
    exp_broj = exp_broj + 16'd3;
    if (nres == 3) begin
      checks++; if (t[1] - t[0] !== 63 || t[2] - t[1] !== 63) begin
        errors++; $display("FAIL stream_spacing: got %0d,%0d need 63,63", t[1] - t[0], t[2] - t[1]); end
    end
    checks++; if (veza.broj_uzoraka !== exp_broj || veza.rez_valid !== 1'b0) begin
      errors++; $display("FAIL stream_broj: got %h v %b need %h 0", veza.broj_uzoraka, veza.rez_valid, exp_broj); end
    $display("test_streaming done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_load();
    test_gapped_discard();
    test_streaming();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
